// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Instruction-supply side of the MiniMIPS single-cycle core. Holds a
//   2^ADDR_WIDTH x INSTR_WIDTH instruction store that is filled through a
//   valid/ready load port. It owns the program counter and presents one
//   instruction per cycle, with zero fetch latency, to the core. The core's
//   branch decision and offset come back to form the next PC. A run stops
//   when the fetched word equals HALT_WORD.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   load_en                request/hold load mode
//   load_valid, load_data  word offered for loading
//   load_ready             store accepts a word this cycle (no path from load_valid)
//   start                  begin execution at PC 0 (from IDLE or HALTED)
//   branch_taken           core's branch decision for the current instruction
//   branch_offset          signed word offset, added on top of pc + 1
//   instruction            store[pc] in RUN, otherwise 0
//   instr_valid            live, non-halt instruction is being presented
//   pc                     current program counter
//   load_count             words loaded in the current load session (0..2^ADDR_WIDTH)
//   instr_count            instructions issued in the current run (saturating)
//   busy                   state is LOAD or RUN
//   done                   state is HALTED
module instruction_fetch_unit #(
  parameter int                ADDR_WIDTH  = 6,
  parameter int                INSTR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD = 16'hFFFF,
  parameter int                COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  output logic                   load_ready,
  input  logic                   start,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_offset,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [ADDR_WIDTH:0]    load_count,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]             state;
  logic [INSTR_WIDTH-1:0] store [DEPTH];
  logic [INSTR_WIDTH-1:0] fetch_word;
  logic                   fetch_is_halt;
  logic                   load_fire;
  logic                   load_last;

  // Next PC: the offset is a two's-complement word offset; the sum is taken
  // modulo the store depth, so both forward and backward branches wrap.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(
    input logic [ADDR_WIDTH-1:0]        cur,
    input logic                         taken,
    input logic signed [ADDR_WIDTH-1:0] offset
  );
    logic signed [ADDR_WIDTH-1:0] step;
    step = taken ? offset : '0;
    return cur + ADDR_WIDTH'(1) + $unsigned(step);
  endfunction

  // Issued-instruction counter sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] cnt
  );
    return (cnt == '1) ? cnt : cnt + COUNT_WIDTH'(1);
  endfunction

  assign fetch_word    = store[pc];
  assign fetch_is_halt = (fetch_word == HALT_WORD);

  // The MSB of load_count marks a full store, so ready depends only on
  // state and count.
  assign load_ready = (state == ST_LOAD) && !load_count[ADDR_WIDTH];
  assign load_fire  = load_ready && load_valid;
  assign load_last  = load_fire &&
                      (load_count == (ADDR_WIDTH + 1)'(DEPTH - 1));

  assign instruction = (state == ST_RUN) ? fetch_word : '0;
  assign instr_valid = (state == ST_RUN) && !fetch_is_halt;
  assign busy        = (state == ST_LOAD) || (state == ST_RUN);
  assign done        = (state == ST_HALTED);

  // Instruction store: reset fills every entry with HALT_WORD so any
  // unloaded location stops a run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= HALT_WORD;
      end
    end else if (load_fire) begin
      store[load_count[ADDR_WIDTH-1:0]] <= load_data;
    end
  end

  // Control FSM, program counter and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      load_count  <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          // load_en has priority over start.
          if (load_en) begin
            state      <= ST_LOAD;
            load_count <= '0;
          end else if (start) begin
            state       <= ST_RUN;
            pc          <= '0;
            instr_count <= '0;
          end
        end
        ST_LOAD: begin
          if (load_fire) begin
            load_count <= load_count + (ADDR_WIDTH + 1)'(1);
          end
          // A handshake on the closing edge is still written above.
          if (load_last || !load_en) begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (fetch_is_halt) begin
            state <= ST_HALTED;
          end else begin
            pc          <= next_pc(pc, branch_taken, $signed(branch_offset));
            instr_count <= sat_inc(instr_count);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: a table of per-cycle vectors for the
// load/run/halt/restart flow, plus hand-written sequences for a full 64-word
// load with branches and mid-run reset, and a load with valid gaps.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        start;
  logic        branch_taken;
  logic [5:0]  branch_offset;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [5:0]  pc;
  logic [6:0]  load_count;
  logic [15:0] instr_count;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .start         (start),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .load_count    (load_count),
    .instr_count   (instr_count),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        le;
    logic        lv;
    logic [15:0] ld;
    logic        st;
    logic        bt;
    logic [5:0]  bo;
    logic [15:0] e_instr;
    logic        e_vld;
    logic [5:0]  e_pc;
    logic [6:0]  e_lc;
    logic [15:0] e_ic;
    logic        e_busy;
    logic        e_done;
    logic        e_rdy;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = 16'h0;
    start = 1'b0; branch_taken = 1'b0; branch_offset = 6'd0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // Outputs are checked 1 time unit after the negedge; the vector's inputs
    // then take effect on the following posedge.
    //          rst   le    lv    ld        st    bt    bo     instr     vld   pc     lc     ic      busy  done  rdy
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 7'd0, 16'd0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 7'd1, 16'd0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 7'd2, 16'd0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 7'd3, 16'd0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 7'd3, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'h1234, 1'b1, 6'd0, 7'd3, 16'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'h5678, 1'b1, 6'd1, 7'd3, 16'd1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'd3, 16'hFFFF, 1'b0, 6'd2, 7'd3, 16'd2, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd2, 7'd3, 16'd2, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'h1234, 1'b1, 6'd0, 7'd3, 16'd0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'h5678, 1'b1, 6'd1, 7'd3, 16'd1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'hFFFF, 1'b0, 6'd2, 7'd3, 16'd2, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd2, 7'd3, 16'd2, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd2, 7'd0, 16'd2, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd2, 7'd0, 16'd2, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd2, 7'd0, 16'd2, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'h0000, 1'b0, 6'd2, 7'd0, 16'd2, 1'b0, 1'b0, 1'b0};

    @(negedge clk);

    // ---------------- table-driven run ----------------
    for (int i = 0; i < NVEC; i++) begin
      reset = vecs[i].rst; load_en = vecs[i].le; load_valid = vecs[i].lv;
      load_data = vecs[i].ld; start = vecs[i].st; branch_taken = vecs[i].bt;
      branch_offset = vecs[i].bo;
      #1;
      check($sformatf("v%0d instruction", i), 32'(instruction), 32'(vecs[i].e_instr));
      check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_vld));
      check($sformatf("v%0d pc", i),          32'(pc),          32'(vecs[i].e_pc));
      check($sformatf("v%0d load_count", i),  32'(load_count),  32'(vecs[i].e_lc));
      check($sformatf("v%0d instr_count", i), 32'(instr_count), 32'(vecs[i].e_ic));
      check($sformatf("v%0d busy", i),        32'(busy),        32'(vecs[i].e_busy));
      check($sformatf("v%0d done", i),        32'(done),        32'(vecs[i].e_done));
      check($sformatf("v%0d load_ready", i),  32'(load_ready),  32'(vecs[i].e_rdy));
      @(negedge clk);
    end

    // ---------------- full 64-word load, branches, reset mid-run ----------------
    idle_inputs();
    reset = 1'b1; #1; reset = 1'b0;
    load_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      load_valid = 1'b1;
      load_data  = 16'h0100 + 16'(k);
      #1;
      check($sformatf("full k%0d load_ready", k), 32'(load_ready), 32'd1);
      @(negedge clk);
    end
    load_en = 1'b0; load_valid = 1'b1; load_data = 16'hBEEF;
    #1;
    check("full ready_low", 32'(load_ready), 32'd0);
    check("full load_count", 32'(load_count), 32'd64);
    check("full busy_idle", 32'(busy), 32'd0);
    @(negedge clk);
    load_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("full word0_kept", 32'(instruction), 32'h0100);
    check("full run_pc0", 32'(pc), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("full pc5_instr", 32'(instruction), 32'h0105);
    branch_taken = 1'b1; branch_offset = 6'b111110;
    @(negedge clk);
    branch_taken = 1'b0; branch_offset = 6'd0;
    #1;
    check("branch back pc", 32'(pc), 32'd4);
    check("branch back ic", 32'(instr_count), 32'd6);
    repeat (58) @(negedge clk);
    #1;
    check("pc62 pc", 32'(pc), 32'd62);
    check("pc62 instr", 32'(instruction), 32'h013E);
    branch_taken = 1'b1; branch_offset = 6'd3;
    @(negedge clk);
    branch_taken = 1'b0; branch_offset = 6'd0;
    #1;
    check("branch wrap pc", 32'(pc), 32'd2);
    check("branch wrap ic", 32'(instr_count), 32'd65);
    repeat (8) @(negedge clk);
    #1;
    check("pre_reset pc", 32'(pc), 32'd10);
    reset = 1'b1;
    #1;
    check("async_rst pc", 32'(pc), 32'd0);
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst done", 32'(done), 32'd0);
    check("async_rst instruction", 32'(instruction), 32'd0);
    check("async_rst instr_valid", 32'(instr_valid), 32'd0);
    check("async_rst load_count", 32'(load_count), 32'd0);
    check("async_rst instr_count", 32'(instr_count), 32'd0);
    check("async_rst load_ready", 32'(load_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("post_rst halt_word", 32'(instruction), 32'hFFFF);
    check("post_rst instr_valid", 32'(instr_valid), 32'd0);
    check("post_rst busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check("post_rst done", 32'(done), 32'd1);
    check("post_rst pc", 32'(pc), 32'd0);
    check("post_rst instr_count", 32'(instr_count), 32'd0);

    // ---------------- load with valid gaps ----------------
    begin
      logic        gv [7];
      logic [15:0] gd [7];
      gv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      gd = '{16'hA1A1, 16'hDEAD, 16'hDEAD, 16'hB2B2, 16'hDEAD, 16'hDEAD, 16'hC3C3};
      @(negedge clk);
      idle_inputs();
      reset = 1'b1; #1; reset = 1'b0;
      load_en = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 7; j++) begin
        load_valid = gv[j];
        load_data  = gd[j];
        @(negedge clk);
      end
      load_valid = 1'b0; load_en = 1'b0;
      #1;
      check("gap load_count", 32'(load_count), 32'd3);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("gap word0", 32'(instruction), 32'hA1A1);
      @(negedge clk); #1;
      check("gap word1", 32'(instruction), 32'hB2B2);
      @(negedge clk); #1;
      check("gap word2", 32'(instruction), 32'hC3C3);
      @(negedge clk); #1;
      check("gap word3_halt", 32'(instruction), 32'hFFFF);
      check("gap pc3", 32'(pc), 32'd3);
      @(negedge clk); #1;
      check("gap done", 32'(done), 32'd1);
      check("gap instr_count", 32'(instr_count), 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
